// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with dual CDB writeback, single-entry retire and mispredict rollback
module reorder_buffer #(
  parameter int ROB_SIZE     = 16,
  parameter int ROB_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_signal_from_dispatcher,
  input  logic [4:0]              rd_from_dispatcher,
  input  logic [1:0]              type_from_dispatcher,
  input  logic                    pred_taken_from_dispatcher,
  input  logic [31:0]             pc_from_dispatcher,
  output logic [ROB_ID_WIDTH-1:0] rob_id_to_dispatcher,
  output logic                    full_to_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] query_id1_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] query_id2_from_dispatcher,
  output logic                    ready1_to_dispatcher,
  output logic                    ready2_to_dispatcher,
  output logic [31:0]             value1_to_dispatcher,
  output logic [31:0]             value2_to_dispatcher,
  input  logic                    alu_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]             alu_value,
  input  logic                    alu_taken,
  input  logic [31:0]             alu_target,
  input  logic                    lsb_valid,
  input  logic [ROB_ID_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]             lsb_value,
  output logic                    commit_flag,
  output logic [4:0]              rd_to_reg,
  output logic [ROB_ID_WIDTH-1:0] Q_to_reg,
  output logic [31:0]             V_to_reg,
  output logic                    store_commit_flag,
  output logic [ROB_ID_WIDTH-1:0] store_rob_id,
  output logic                    rollback_flag,
  output logic [31:0]             target_pc
);
  localparam int IW = $clog2(ROB_SIZE);
  localparam logic [1:0] BRANCH = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [ROB_ID_WIDTH-1:0] ONE = ROB_ID_WIDTH'(1);
  logic [ROB_SIZE-1:0] busy, ready, pred, real_t;
  logic [1:0]  typ    [ROB_SIZE];
  logic [4:0]  rd     [ROB_SIZE];
  logic [31:0] value  [ROB_SIZE];
  logic [31:0] pc     [ROB_SIZE];
  logic [31:0] target [ROB_SIZE];
  logic [IW-1:0] head, tail, alu_idx, lsb_idx;
  logic [IW:0] count;
  logic alu_hit, lsb_hit, commit, rollback, alloc_ok;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return p == IW'(ROB_SIZE - 1) ? '0 : p + 1'b1;
  endfunction
  // Tag 0 is always ready; a same-cycle CDB broadcast beats the stored entry, ALU first.
  function automatic logic [32:0] lookup(input logic [ROB_ID_WIDTH-1:0] id);
    logic [IW-1:0] i;
    i = IW'(id - ONE);
    return id == '0 ? {1'b1, 32'd0} :
           (alu_valid && alu_rob_id == id) ? {1'b1, alu_value} :
           (lsb_valid && lsb_rob_id == id) ? {1'b1, lsb_value} : {ready[i], value[i]};
  endfunction
  always_comb begin
    rob_id_to_dispatcher = ROB_ID_WIDTH'(tail) + ONE;
    full_to_dispatcher = count == (IW+1)'(ROB_SIZE);
    {ready1_to_dispatcher, value1_to_dispatcher} = lookup(query_id1_from_dispatcher);
    {ready2_to_dispatcher, value2_to_dispatcher} = lookup(query_id2_from_dispatcher);
    alu_idx = IW'(alu_rob_id - ONE);
    lsb_idx = IW'(lsb_rob_id - ONE);
    alu_hit = alu_valid && alu_rob_id != '0 && alu_rob_id <= ROB_ID_WIDTH'(ROB_SIZE) && busy[alu_idx];
    lsb_hit = lsb_valid && lsb_rob_id != '0 && lsb_rob_id <= ROB_ID_WIDTH'(ROB_SIZE) && busy[lsb_idx]
              && !(alu_hit && alu_idx == lsb_idx);
    commit = rdy && count != '0 && busy[head] && ready[head];
    rollback = commit && typ[head] == BRANCH && real_t[head] != pred[head];
    alloc_ok = rdy && alloc_signal_from_dispatcher && !full_to_dispatcher && !rollback;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      ready <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      commit_flag <= 1'b0;
      store_commit_flag <= 1'b0;
      rollback_flag <= 1'b0;
      rd_to_reg <= '0;
      Q_to_reg <= '0;
      V_to_reg <= '0;
      store_rob_id <= '0;
      target_pc <= '0;
    end else begin
      commit_flag <= commit;
      store_commit_flag <= commit && typ[head] == STORE;
      rollback_flag <= rollback;
      if (commit) begin
        rd_to_reg <= rd[head];
        Q_to_reg <= ROB_ID_WIDTH'(head) + ONE;
        V_to_reg <= value[head];
      end
      if (commit && typ[head] == STORE) store_rob_id <= ROB_ID_WIDTH'(head) + ONE;
      if (rollback) target_pc <= real_t[head] ? target[head] : pc[head] + 32'd4;
      if (rdy) begin
        if (alu_hit) begin
          ready[alu_idx] <= 1'b1;
          value[alu_idx] <= alu_value;
          real_t[alu_idx] <= alu_taken;
          target[alu_idx] <= alu_target;
        end
        if (lsb_hit) begin
          ready[lsb_idx] <= 1'b1;
          value[lsb_idx] <= lsb_value;
        end
        if (alloc_ok) begin
          busy[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          real_t[tail] <= 1'b0;
          typ[tail] <= type_from_dispatcher;
          rd[tail] <= rd_from_dispatcher;
          pc[tail] <= pc_from_dispatcher;
          pred[tail] <= pred_taken_from_dispatcher;
          tail <= nxt(tail);
        end
        if (commit) begin
          busy[head] <= 1'b0;
          ready[head] <= 1'b0;
          head <= nxt(head);
        end
        if (rollback) begin
          busy <= '0;
          ready <= '0;
          head <= '0;
          tail <= '0;
          count <= '0;
        end else count <= count + (IW+1)'(alloc_ok) - (IW+1)'(commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: random + directed stimulus against a queue-based ROB model
module tb_reorder_buffer;
  logic clk = 0, rst = 1, rdy = 1;
  logic alloc_signal_from_dispatcher = 0;
  logic [4:0] rd_from_dispatcher = 0;
  logic [1:0] type_from_dispatcher = 0;
  logic pred_taken_from_dispatcher = 0;
  logic [31:0] pc_from_dispatcher = 0;
  logic [4:0] rob_id_to_dispatcher;
  logic full_to_dispatcher;
  logic [4:0] query_id1_from_dispatcher = 0, query_id2_from_dispatcher = 0;
  logic ready1_to_dispatcher, ready2_to_dispatcher;
  logic [31:0] value1_to_dispatcher, value2_to_dispatcher;
  logic alu_valid = 0, alu_taken = 0, lsb_valid = 0;
  logic [4:0] alu_rob_id = 0, lsb_rob_id = 0;
  logic [31:0] alu_value = 0, alu_target = 0, lsb_value = 0;
  logic commit_flag, store_commit_flag, rollback_flag;
  logic [4:0] rd_to_reg, Q_to_reg, store_rob_id;
  logic [31:0] V_to_reg, target_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_signal_from_dispatcher(alloc_signal_from_dispatcher),
    .rd_from_dispatcher(rd_from_dispatcher),
    .type_from_dispatcher(type_from_dispatcher),
    .pred_taken_from_dispatcher(pred_taken_from_dispatcher),
    .pc_from_dispatcher(pc_from_dispatcher),
    .rob_id_to_dispatcher(rob_id_to_dispatcher),
    .full_to_dispatcher(full_to_dispatcher),
    .query_id1_from_dispatcher(query_id1_from_dispatcher),
    .query_id2_from_dispatcher(query_id2_from_dispatcher),
    .ready1_to_dispatcher(ready1_to_dispatcher),
    .ready2_to_dispatcher(ready2_to_dispatcher),
    .value1_to_dispatcher(value1_to_dispatcher),
    .value2_to_dispatcher(value2_to_dispatcher),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .alu_taken(alu_taken), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_flag(commit_flag), .rd_to_reg(rd_to_reg), .Q_to_reg(Q_to_reg),
    .V_to_reg(V_to_reg), .store_commit_flag(store_commit_flag),
    .store_rob_id(store_rob_id), .rollback_flag(rollback_flag), .target_pc(target_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the ROB as an ordered list of in-flight instructions, oldest first.
  typedef struct {
    int tag;
    bit [1:0] typ;
    bit [4:0] rd;
    bit done;
    bit [31:0] val, pc, tgt;
    bit pred, taken;
  } ent_t;
  ent_t rob[$];
  ent_t h, ne;
  int next_tag = 1;
  bit started = 0, c, rb, al;
  bit e_commit, e_store, e_rb;
  bit [4:0] e_rd, e_q, e_sid;
  bit [31:0] e_v, e_tpc;

  always @(posedge clk) begin
    if (rst) begin
      rob.delete();
      next_tag = 1;
      started = 1;
      {e_commit, e_store, e_rb} = 3'b000;
      {e_rd, e_q, e_sid, e_v, e_tpc} = '0;
    end else if (started && !rdy) begin
      {e_commit, e_store, e_rb} = 3'b000;
    end else if (started) begin
      c = rob.size() > 0 && rob[0].done;
      h = c ? rob[0] : '{default: 0};
      rb = c && h.typ == 2'd1 && h.taken != h.pred;
      al = alloc_signal_from_dispatcher && rob.size() < 16 && !rb;
      e_commit = c;
      e_store = c && h.typ == 2'd2;
      e_rb = rb;
      if (c) begin e_rd = h.rd; e_q = 5'(h.tag); e_v = h.val; end
      if (e_store) e_sid = 5'(h.tag);
      if (rb) e_tpc = h.taken ? h.tgt : h.pc + 32'd4;
      foreach (rob[i]) begin
        if (alu_valid && alu_rob_id == rob[i].tag) begin
          rob[i].done = 1; rob[i].val = alu_value; rob[i].taken = alu_taken; rob[i].tgt = alu_target;
        end else if (lsb_valid && lsb_rob_id == rob[i].tag) begin
          rob[i].done = 1; rob[i].val = lsb_value;
        end
      end
      if (al) begin
        ne = '{default: 0};
        ne.tag = next_tag; ne.typ = type_from_dispatcher; ne.rd = rd_from_dispatcher;
        ne.pc = pc_from_dispatcher; ne.pred = pred_taken_from_dispatcher;
        rob.push_back(ne);
        next_tag = next_tag % 16 + 1;
      end
      if (c) void'(rob.pop_front());
      if (rb) begin rob.delete(); next_tag = 1; end
    end
  end

  function automatic void qexp(input bit [4:0] id, output bit r, output bit [31:0] v);
    r = 0; v = 0;
    if (id == 0) r = 1;
    else if (alu_valid && alu_rob_id == id) begin r = 1; v = alu_value; end
    else if (lsb_valid && lsb_rob_id == id) begin r = 1; v = lsb_value; end
    else foreach (rob[i]) if (rob[i].tag == id) begin r = rob[i].done; v = rob[i].val; end
  endfunction

  bit qr;
  bit [31:0] qv;
  always @(negedge clk) if (started) begin
    chk("rob_id", rob_id_to_dispatcher, next_tag);
    chk("full", full_to_dispatcher, rob.size() == 16);
    chk("commit_flag", commit_flag, e_commit);
    chk("store_commit_flag", store_commit_flag, e_store);
    chk("rollback_flag", rollback_flag, e_rb);
    if (e_commit) begin
      chk("rd_to_reg", rd_to_reg, e_rd);
      chk("Q_to_reg", Q_to_reg, e_q);
      chk("V_to_reg", V_to_reg, e_v);
    end
    if (e_store) chk("store_rob_id", store_rob_id, e_sid);
    if (e_rb) chk("target_pc", target_pc, e_tpc);
    qexp(query_id1_from_dispatcher, qr, qv);
    chk("ready1", ready1_to_dispatcher, qr);
    if (qr) chk("value1", value1_to_dispatcher, qv);
    qexp(query_id2_from_dispatcher, qr, qv);
    chk("ready2", ready2_to_dispatcher, qr);
    if (qr) chk("value2", value2_to_dispatcher, qv);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    alloc_signal_from_dispatcher = 0; alu_valid = 0; lsb_valid = 0;
    query_id1_from_dispatcher = 0; query_id2_from_dispatcher = 0;
  endtask
  task automatic alloc(input logic [1:0] t, input logic [4:0] r, input logic [31:0] p, input logic pr);
    alloc_signal_from_dispatcher = 1; type_from_dispatcher = t; rd_from_dispatcher = r;
    pc_from_dispatcher = p; pred_taken_from_dispatcher = pr;
  endtask
  task automatic alu(input logic [4:0] id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    alu_valid = 1; alu_rob_id = id; alu_value = v; alu_taken = tk; alu_target = tg;
  endtask
  task automatic lsb(input logic [4:0] id, input logic [31:0] v);
    lsb_valid = 1; lsb_rob_id = id; lsb_value = v;
  endtask
  task automatic do_reset();
    idle(); rst = 1; rdy = 1; cyc(); rst = 0;
  endtask

  function automatic logic [4:0] pick();
    if (rob.size() > 0 && $urandom_range(0, 3) != 0) return 5'(rob[$urandom_range(0, rob.size() - 1)].tag);
    return 5'($urandom_range(0, 16));
  endfunction

  initial begin
    // reset state
    cyc(); cyc(); rst = 0;
    chk("reset commit_flag", commit_flag, 0);
    chk("reset rd/Q/V", {27'd0, rd_to_reg} | {27'd0, Q_to_reg} | V_to_reg, 0);
    chk("reset target_pc", target_pc, 0);
    chk("reset rob_id", rob_id_to_dispatcher, 1);
    // single NORMAL instruction round trip
    alloc(0, 5, 0, 0); cyc(); idle();
    alu(1, 32'h2A, 0, 0); cyc(); idle(); cyc();
    chk("t1 commit_flag", commit_flag, 1);
    chk("t1 rd_to_reg", rd_to_reg, 5);
    chk("t1 Q_to_reg", Q_to_reg, 1);
    chk("t1 V_to_reg", V_to_reg, 32'h2A);
    cyc();
    chk("t1 drained full", full_to_dispatcher, 0);
    // fill, overflow, wrap, and full-boundary commit+alloc
    do_reset();
    for (int i = 0; i < 16; i++) begin alloc(0, 5'(i + 1), 32'(i * 4), 0); cyc(); end
    #1 chk("t2 full", full_to_dispatcher, 1);
    alloc(0, 9, 0, 0); cyc(); idle();
    #1 chk("t2 overflow rob_id", rob_id_to_dispatcher, 1);
    alu(1, 32'h11, 0, 0); cyc(); idle(); cyc();
    chk("t2 commit Q", Q_to_reg, 1);
    #1 chk("t2 not full", full_to_dispatcher, 0);
    chk("t2 wrap tag", rob_id_to_dispatcher, 1);
    alloc(0, 3, 0, 0); cyc(); idle();
    #1 chk("t2 full again", full_to_dispatcher, 1);
    alu(2, 32'h22, 0, 0); cyc(); idle();
    alloc(0, 4, 0, 0); cyc(); idle();
    chk("t2 boundary commit Q", Q_to_reg, 2);
    #1 chk("t2 boundary alloc dropped", rob_id_to_dispatcher, 2);
    // out-of-order completion, in-order retire
    do_reset();
    for (int i = 1; i <= 3; i++) begin alloc(0, 5'(i), 0, 0); cyc(); end
    idle(); alu(3, 32'h33, 0, 0); cyc();
    idle(); alu(1, 32'h11, 0, 0); cyc();
    idle(); lsb(2, 32'h22); cyc();
    chk("t3 first Q", Q_to_reg, 1);
    idle(); cyc();
    chk("t3 second Q", Q_to_reg, 2);
    cyc();
    chk("t3 third Q", Q_to_reg, 3);
    chk("t3 third V", V_to_reg, 32'h33);
    // mispredicted branch flushes younger entries
    do_reset();
    alloc(1, 0, 32'h100, 0); cyc();
    alloc(0, 7, 32'h104, 0); cyc();
    alloc(0, 8, 32'h108, 0); cyc(); idle();
    alu(1, 0, 1, 32'h200); lsb(2, 32'h77); cyc(); idle();
    lsb(3, 32'h88); cyc(); idle();
    chk("t4 rollback_flag", rollback_flag, 1);
    chk("t4 target_pc", target_pc, 32'h200);
    #1 chk("t4 rob_id reset", rob_id_to_dispatcher, 1);
    cyc();
    chk("t4 no younger commit", commit_flag, 0);
    // query bypass
    do_reset();
    alloc(0, 1, 0, 0); cyc(); alloc(0, 2, 0, 0); cyc(); idle();
    alu(2, 7, 0, 0); query_id2_from_dispatcher = 2; query_id1_from_dispatcher = 0;
    #1 chk("t5 ready2", ready2_to_dispatcher, 1);
    chk("t5 value2", value2_to_dispatcher, 7);
    chk("t5 ready1 tag0", ready1_to_dispatcher, 1);
    chk("t5 value1 tag0", value1_to_dispatcher, 0);
    query_id1_from_dispatcher = 1;
    #1 chk("t5 ready1 pending", ready1_to_dispatcher, 0);
    cyc(); idle();
    // stall with rdy low, then a STORE retires once
    do_reset();
    alloc(2, 0, 32'h40, 0); cyc(); idle();
    lsb(1, 32'h5); cyc(); idle();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin cyc(); chk("t6 stalled commit", commit_flag, 0); end
    rdy = 1; cyc();
    chk("t6 commit", commit_flag, 1);
    chk("t6 store flag", store_commit_flag, 1);
    chk("t6 store id", store_rob_id, 1);
    cyc();
    chk("t6 store not held", store_commit_flag, 0);
    // reset mid-operation while frozen
    alloc(0, 3, 0, 0); cyc(); alloc(0, 4, 0, 0); cyc(); idle();
    rdy = 0; rst = 1; cyc(); rst = 0; rdy = 1;
    #1 chk("t7 rob_id after reset", rob_id_to_dispatcher, 1);
    // randomized traffic, first biased to fill, then balanced
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      rdy = $urandom_range(0, 9) != 0;
      alloc_signal_from_dispatcher = $urandom_range(0, 9) < (n < 2000 ? 8 : 5);
      type_from_dispatcher = 2'($urandom_range(0, 2));
      rd_from_dispatcher = type_from_dispatcher == 2 ? 5'd0 : 5'($urandom);
      pred_taken_from_dispatcher = 1'($urandom);
      pc_from_dispatcher = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      alu_valid = $urandom_range(0, 9) < (n < 2000 ? 3 : 6);
      alu_rob_id = pick(); alu_value = $urandom; alu_taken = 1'($urandom); alu_target = $urandom;
      lsb_valid = $urandom_range(0, 9) < (n < 2000 ? 2 : 5);
      lsb_rob_id = pick(); lsb_value = $urandom;
      query_id1_from_dispatcher = 5'($urandom_range(0, 16));
      query_id2_from_dispatcher = $urandom_range(0, 3) == 0 ? alu_rob_id : 5'($urandom_range(0, 16));
      cyc();
    end
    idle(); rst = 0; rdy = 1; cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
